// File: rtl/run_caller.sv
// run_caller: issues one run_req call per accepted operand, waits for the
// callee to finish, counts completions and traps a hung or silent callee.
module run_caller #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ce,
    input  logic              i_op_valid,
    output logic              o_op_ready,
    input  logic [DATA_W-1:0] i_op_data,
    output logic              o_run_req,
    output logic [DATA_W-1:0] o_run_input_a_0,
    input  logic              i_run_busy,
    output logic              o_done,
    output logic [CNT_W-1:0]  o_call_count,
    output logic              o_timeout,
    output logic              o_idle
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ACK,
        S_RUN,
        S_DONE,
        S_ERR
    } state_t;

    state_t          r_state;
    logic [WD_W-1:0] r_wdog;
    logic            r_miss;
    logic [WD_W-1:0] w_wdog_nxt;
    logic            w_accept;

    assign w_wdog_nxt = r_wdog + WD_W'(1);
    assign w_accept   = i_op_valid & o_op_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_wdog          <= '0;
            r_miss          <= 1'b0;
            o_op_ready      <= 1'b0;
            o_run_req       <= 1'b0;
            o_run_input_a_0 <= '0;
            o_done          <= 1'b0;
            o_call_count    <= '0;
            o_timeout       <= 1'b0;
            o_idle          <= 1'b0;
        end else if (ce) begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        o_run_input_a_0 <= i_op_data;
                        o_run_req       <= 1'b1;
                        o_op_ready      <= 1'b0;
                        o_idle          <= 1'b0;
                        r_state         <= S_REQ;
                    end else begin
                        o_op_ready <= 1'b1;
                        o_idle     <= 1'b1;
                    end
                end
                S_REQ: begin
                    o_run_req <= 1'b0;
                    r_miss    <= 1'b0;
                    r_state   <= S_ACK;
                end
                S_ACK: begin
                    // a callee that never raises busy is caught after two cycles
                    if (i_run_busy) begin
                        r_wdog  <= '0;
                        r_state <= S_RUN;
                    end else if (r_miss) begin
                        o_timeout <= 1'b1;
                        r_state   <= S_ERR;
                    end else begin
                        r_miss <= 1'b1;
                    end
                end
                S_RUN: begin
                    // completion is checked first so it wins over the watchdog
                    if (!i_run_busy) begin
                        o_done       <= 1'b1;
                        o_call_count <= o_call_count + CNT_W'(1);
                        r_state      <= S_DONE;
                    end else if (w_wdog_nxt == WD_MAX) begin
                        o_timeout <= 1'b1;
                        r_state   <= S_ERR;
                    end else begin
                        r_wdog <= w_wdog_nxt;
                    end
                end
                S_DONE: begin
                    o_done     <= 1'b0;
                    o_op_ready <= 1'b1;
                    o_idle     <= 1'b1;
                    r_state    <= S_IDLE;
                end
                S_ERR: begin
                    o_timeout  <= 1'b1;
                    o_op_ready <= 1'b0;
                    o_run_req  <= 1'b0;
                    o_idle     <= 1'b0;
                end
                default: begin
                    r_state <= S_ERR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_run_caller.sv
// tb_run_caller: drives operands into run_caller against a behavioural
// callee and checks the call sequence through an operand scoreboard.
module tb_run_caller;

    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 64;
    localparam int CNT_W   = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              ce = 1'b1;
    logic              i_op_valid = 1'b0;
    logic [DATA_W-1:0] i_op_data = '0;
    logic              o_op_ready;
    logic              o_run_req;
    logic [DATA_W-1:0] o_run_input_a_0;
    logic              i_run_busy;
    logic              o_done;
    logic [CNT_W-1:0]  o_call_count;
    logic              o_timeout;
    logic              o_idle;

    run_caller #(
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .ce             (ce),
        .i_op_valid     (i_op_valid),
        .o_op_ready     (o_op_ready),
        .i_op_data      (i_op_data),
        .o_run_req      (o_run_req),
        .o_run_input_a_0(o_run_input_a_0),
        .i_run_busy     (i_run_busy),
        .o_done         (o_done),
        .o_call_count   (o_call_count),
        .o_timeout      (o_timeout),
        .o_idle         (o_idle)
    );

    always #5 clock = ~clock;

    // callee: 0 normal, 1 busy stuck high, 2 never acks
    int   mode = 0;
    int   busy_len = 6;
    int   rem;
    logic r_busy;

    assign i_run_busy = r_busy;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            r_busy <= 1'b0;
            rem    <= 0;
        end else if (ce) begin
            if (o_run_req) begin
                if (mode != 2) begin
                    r_busy <= 1'b1;
                    rem    <= busy_len - 1;
                end
            end else if (r_busy && mode == 0) begin
                if (rem == 0) r_busy <= 1'b0;
                else rem <= rem - 1;
            end
        end
    end

    int n_tests = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [DATA_W-1:0] sb[$];
    logic [DATA_W-1:0] cur_op;
    logic              ce_tog = 1'b0;
    logic [63:0]       prev_outs;
    logic              prev_ce, have_prev;
    logic              prev_req, prev_done, p_req_s, p_done_s, p_to_s;
    int                smp = 0, cyc = 0, last_req = -1;
    int                req_cnt = 0, done_cnt = 0, done_smp = 0;
    int                t_req = 0, lat_done = -1, lat_to = -1;

    function automatic logic [63:0] outs();
        return 64'({o_op_ready, o_run_req, o_done, o_timeout, o_idle,
                    o_call_count, o_run_input_a_0});
    endfunction

    task automatic sample();
        smp++;
        if (reset) begin
            have_prev = 1'b0;
            last_req  = -1;
            prev_req  = 1'b0;
            prev_done = 1'b0;
            p_req_s   = 1'b0;
            p_done_s  = 1'b0;
            p_to_s    = 1'b0;
        end else begin
            if (have_prev && !prev_ce) check("freeze", outs(), prev_outs);
            if (ce) begin
                cyc++;
                if (o_run_req) begin
                    req_cnt++;
                    check("req_1cyc", 64'(prev_req), 64'd0);
                    check("req_busy", 64'(i_run_busy), 64'd0);
                    if (last_req >= 0)
                        check("req_gap", 64'(cyc - last_req >= 4), 64'd1);
                    last_req = cyc;
                    if (sb.size() == 0) check("sb_empty", 64'd0, 64'd1);
                    else check("op", 64'(o_run_input_a_0), 64'(sb.pop_front()));
                    cur_op = o_run_input_a_0;
                end
                if (i_run_busy)
                    check("op_hold", 64'(o_run_input_a_0), 64'(cur_op));
                if (o_done) begin
                    done_cnt++;
                    check("done_1cyc", 64'(prev_done), 64'd0);
                end
                prev_req  = o_run_req;
                prev_done = o_done;
            end
            if (o_run_req && !p_req_s) t_req = smp;
            if (o_done && !p_done_s) lat_done = smp - t_req;
            if (o_timeout && !p_to_s) lat_to = smp - t_req;
            if (o_done) done_smp++;
            p_req_s   = o_run_req;
            p_done_s  = o_done;
            p_to_s    = o_timeout;
            prev_outs = outs();
            prev_ce   = ce;
            have_prev = 1'b1;
        end
    endtask

    task automatic step();
        @(negedge clock);
        ce = ce_tog ? ~ce : 1'b1;
        #1;
        sample();
    endtask

    task automatic send(input logic [DATA_W-1:0] op);
        int t = 0;
        i_op_valid = 1'b1;
        i_op_data  = op;
        while (!(o_op_ready && ce) && t < 500) begin
            step();
            t++;
        end
        check("send_wait", 64'(t < 500), 64'd1);
        sb.push_back(op);
        step();
        i_op_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        while (!o_idle && t < budget) begin
            step();
            t++;
        end
        check("idle_wait", 64'(o_idle), 64'd1);
    endtask

    task automatic wait_to(input int budget);
        int t = 0;
        while (!o_timeout && t < budget) begin
            step();
            t++;
        end
        check("timeout_wait", 64'(o_timeout), 64'd1);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        i_op_valid = 1'b0;
        ce_tog     = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int b_req, b_done, b_smp;
        logic [DATA_W-1:0] ops2[4];
        ops2 = '{32'h1111_1111, 32'h2222_2222, 32'hDEAD_BEEF, 32'h0000_0001};

        // reset values, then ready/idle on first ce cycle
        step();
        check("rst_ready", 64'(o_op_ready), 64'd0);
        check("rst_req", 64'(o_run_req), 64'd0);
        check("rst_a0", 64'(o_run_input_a_0), 64'd0);
        check("rst_done", 64'(o_done), 64'd0);
        check("rst_cnt", 64'(o_call_count), 64'd0);
        check("rst_to", 64'(o_timeout), 64'd0);
        check("rst_idle", 64'(o_idle), 64'd0);
        reset = 1'b0;
        step();
        check("ready_rise", 64'(o_op_ready), 64'd1);
        check("idle_rise", 64'(o_idle), 64'd1);

        // single call
        mode = 0; busy_len = 6;
        b_req = req_cnt; b_done = done_cnt;
        send(32'h3F80_0000);
        wait_idle(100);
        check("t1_reqs", 64'(req_cnt - b_req), 64'd1);
        check("t1_dones", 64'(done_cnt - b_done), 64'd1);
        check("t1_count", 64'(o_call_count), 64'd1);
        check("t1_lat", 64'(lat_done), 64'd8);

        // back-to-back with valid held
        do_reset();
        busy_len = 1;
        b_req = req_cnt; b_done = done_cnt;
        for (int i = 0; i < 4; i++) send(ops2[i]);
        wait_idle(100);
        check("t2_reqs", 64'(req_cnt - b_req), 64'd4);
        check("t2_dones", 64'(done_cnt - b_done), 64'd4);
        check("t2_count", 64'(o_call_count), 64'd4);
        check("t2_sb", 64'(sb.size()), 64'd0);

        // busy stuck high
        do_reset();
        mode = 1;
        b_req = req_cnt;
        send(32'hCAFE_0003);
        wait_to(200);
        check("t3_lat", 64'(lat_to), 64'd66);
        i_op_valid = 1'b1;
        i_op_data  = 32'h0BAD_0BAD;
        repeat (20) step();
        check("t3_ready", 64'(o_op_ready), 64'd0);
        check("t3_idle", 64'(o_idle), 64'd0);
        check("t3_sticky", 64'(o_timeout), 64'd1);
        check("t3_reqs", 64'(req_cnt - b_req), 64'd1);
        i_op_valid = 1'b0;

        // callee never acks
        do_reset();
        mode = 2;
        send(32'hCAFE_0004);
        wait_to(20);
        check("t4_lat", 64'(lat_to), 64'd3);
        check("t4_ready", 64'(o_op_ready), 64'd0);

        // ce toggling every cycle
        do_reset();
        mode = 0; busy_len = 6;
        ce_tog = 1'b1;
        b_req = req_cnt; b_done = done_cnt; b_smp = done_smp;
        send(32'h3F80_0000);
        wait_idle(200);
        ce_tog = 1'b0;
        check("t5_lat", 64'(lat_done), 64'd16);
        check("t5_reqs", 64'(req_cnt - b_req), 64'd1);
        check("t5_dones", 64'(done_cnt - b_done), 64'd1);
        check("t5_done_smp", 64'(done_smp - b_smp), 64'd2);
        check("t5_count", 64'(o_call_count), 64'd1);

        // reset mid-RUN, then counter wrap
        do_reset();
        busy_len = 2;
        send(32'h5555_0001);
        wait_idle(100);
        check("t6_pre_cnt", 64'(o_call_count), 64'd1);
        busy_len = 20;
        send(32'h5555_0002);
        repeat (5) step();
        check("t6_mid_busy", 64'(i_run_busy), 64'd1);
        reset = 1'b1;
        #1;
        check("t6_async", outs(), 64'd0);
        step();
        step();
        reset = 1'b0;
        step();
        busy_len = 2;
        b_done = done_cnt;
        for (int i = 0; i < 17; i++) send(32'h1000_0000 + 32'(i));
        wait_idle(100);
        check("t6_dones", 64'(done_cnt - b_done), 64'd17);
        check("t6_wrap", 64'(o_call_count), 64'd1);
        check("t6_sb", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
